bloom_pattern_scanner: RTL
==========================

Name: bloom_pattern_scanner

Overview:
- Streaming, parametrised successor to the single-epoch page comparator block.
- Accepts one block of PPB packed page signatures per handshake and compares every page against up to NPAT programmable patterns.
- Emits the global page number of each matching page, in ascending order, through a buffered valid/ready output, then signals completion after NOB blocks.
- Sits between the flash-page signature fetch path and the FTL lookup logic; replaces the fixed 4-pattern, fixed-array, unbuffered variant.

Parameters:
- P_SIZE, 12, bits per page signature/pattern
- PPB, 64, pages per block (pages compared per accepted beat)
- NOB, 64, blocks per scan
- NPAT, 4, maximum number of patterns
- OUT_DEPTH, 16, output FIFO entries (power of two, ≥2)
- NOP_WIDTH, $clog2(PPB*NOB), global page-number width (derived, 12)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle scan start; honoured only in IDLE
- num_real_patterns  in  $clog2(NPAT+1)  active pattern count; sampled on start
- patterns  in  NPAT*P_SIZE  pattern j at [P_SIZE*(j+1)-1:P_SIZE*j]; sampled on start
- blk_valid  in  1  block beat valid
- blk_ready  out  1  block beat accepted when blk_valid&&blk_ready
- blk_data  in  PPB*P_SIZE  page n at [P_SIZE*(n+1)-1:P_SIZE*n]
- tpn_valid  out  1  output FIFO non-empty
- tpn_ready  in  1  consumer pop
- tpn_data  out  NOP_WIDTH  global true page number (FIFO head, show-ahead)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at scan completion
- match_count  out  NOP_WIDTH+1  total matches in current/last scan

Behaviour:
- Reset (async, rst low): state=IDLE; blk_ready=0, tpn_valid=0, tpn_data=0, busy=0, done=0, match_count=0; FIFO, pending mask, block counter, latched patterns/enables all cleared. Reset mid-scan discards everything; no output survives.
- Pattern enable: en[j] = (j < min(num_real_patterns, NPAT)). num_real_patterns=0 → no page ever matches. Values >NPAT clamp to NPAT.
- Page match: page n matches iff for some enabled j, page == pattern j (full P_SIZE-bit equality).
- FSM: IDLE → SCAN on start (latch patterns/enables, blk_cnt=0, match_count=0). SCAN → DRAIN when blk_cnt==NOB and pending mask==0. DRAIN → DONE when FIFO empty. DONE → IDLE next cycle; done=1 only in DONE. start outside IDLE is ignored.
- Stage 1 (accept): on accept edge, register PPB-bit match vector into pending mask and blk_idx=blk_cnt; blk_cnt++.
- Stage 2 (extract): each cycle with pending≠0 and FIFO not full, push {blk_idx, lowest set bit index} (= blk_idx*PPB + n) into FIFO, clear that bit, match_count++. FIFO full → extraction stalls; no match is ever dropped.
- blk_ready = SCAN && blk_cnt<NOB && (pending==0 || (pending one-hot && !fifo_full)). Zero-match blocks sustain one beat per cycle; a block with m≥1 matches occupies m cycles.
- Latency: block accepted at edge E0 → first match written to FIFO at E1 → tpn_valid high in the cycle after E1 (if FIFO was empty and not full).
- FIFO: simultaneous push and pop when full is not allowed (push stalls); simultaneous push/pop otherwise keeps occupancy. Pointers wrap modulo OUT_DEPTH.
- blk_data is ignored while blk_ready=0; tpn_ready is ignored while tpn_valid=0.
- match_count holds its value after DONE until the next start.

Decomposition:
- Package bloom_scan_pkg: P_SIZE, PPB, NOB, NPAT defaults, NOP_WIDTH derivation, state enum (IDLE, SCAN, DRAIN, DONE).
- Sub-module: page_multi_match (one page vs NPAT patterns with enable vector → 1-bit match), instantiated PPB times via generate.
- FIFO and lowest-set-bit priority encoder are inline.

Test Plan:
- Reset mid-SCAN after 10 beats → all outputs 0, state IDLE; next start scans 64 fresh blocks correctly.
- num_real_patterns=1, pattern0=0xABC, page 5 of block 3 = 0xABC, all else 0 → single tpn_data=197, match_count=1, done pulses once.
- num_real_patterns=2, block 0 pages 0, 1, 63 match pattern1 → outputs 0, 1, 63 in order; blk_ready low for 2 cycles.
- num_real_patterns=0, all pages equal pattern0 → no tpn_valid, match_count=0, done after 64 accepted beats.
- tpn_ready=0, block 7 fully matching (64 matches) → FIFO fills to 16, blk_ready stays low. Release → 448..511 emitted in order, none lost, match_count=64.
- num_real_patterns=7 (clamped to 4), pattern3 = page 0 of block 63 → tpn_data=4032.

Source files
------------

// File: rtl/bloom_scan_pkg.sv
// Shared defaults, derived widths and FSM encoding for the bloom pattern scanner.
package bloom_scan_pkg;

  localparam int DEF_P_SIZE    = 12;  // bits per page signature / pattern
  localparam int DEF_PPB       = 64;  // pages per block beat
  localparam int DEF_NOB       = 64;  // blocks per scan
  localparam int DEF_NPAT      = 4;   // maximum number of patterns
  localparam int DEF_OUT_DEPTH = 16;  // output FIFO entries (power of two)

  // Width of a global page number: enough to address every page in a scan.
  function automatic int nop_width(input int ppb, input int nob);
    return $clog2(ppb * nob);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_e;

endpackage

// File: rtl/page_multi_match.sv
// Compares one page signature against every enabled pattern; 1 on any full equality.
module page_multi_match
  import bloom_scan_pkg::*;
#(
  parameter int P_SIZE = DEF_P_SIZE,
  parameter int NPAT   = DEF_NPAT
) (
  input  logic [P_SIZE-1:0]      page,
  input  logic [NPAT*P_SIZE-1:0] patterns,
  input  logic [NPAT-1:0]        en,
  output logic                   match
);

  // OR of per-pattern equality, gated by the pattern enables.
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
    match = 1'b0;
    for (int j = 0; j < NPAT; j++) begin
      if (en[j] && (page == patterns[j*P_SIZE +: P_SIZE])) match = 1'b1;
    end
  end

endmodule

// File: rtl/bloom_pattern_scanner.sv
// Streaming page-signature scanner: one block of PPB pages per beat is matched
// against up to NPAT patterns; matching global page numbers leave in ascending
// order through a show-ahead FIFO, and done pulses once all NOB blocks drained.
module bloom_pattern_scanner
  import bloom_scan_pkg::*;
#(
  parameter int P_SIZE    = DEF_P_SIZE,
  parameter int PPB       = DEF_PPB,
  parameter int NOB       = DEF_NOB,
  parameter int NPAT      = DEF_NPAT,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH,
  parameter int NOP_WIDTH = nop_width(PPB, NOB)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(NPAT+1)-1:0]  num_real_patterns,
  input  logic [NPAT*P_SIZE-1:0]     patterns,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [PPB*P_SIZE-1:0]      blk_data,
  output logic                       tpn_valid,
  input  logic                       tpn_ready,
  output logic [NOP_WIDTH-1:0]       tpn_data,
  output logic                       busy,
  output logic                       done,
  output logic [NOP_WIDTH:0]         match_count
);

  localparam int CNT_W = $clog2(NOB + 1);
  localparam int IDX_W = (NOB > 1) ? $clog2(NOB) : 1;
  localparam int BIT_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);

  scan_state_e            state_q, state_d;
  logic [NPAT*P_SIZE-1:0] pat_q;
  logic [NPAT-1:0]        en_q, en_d;
  logic [CNT_W-1:0]       blk_cnt_q;
  logic [IDX_W-1:0]       blk_idx_q;
  logic [PPB-1:0]         pending_q, pend_clr, match_vec;
  logic [BIT_W-1:0]       low_idx;
  logic [NOP_WIDTH-1:0]   push_data;
  logic [NOP_WIDTH-1:0]   fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         fifo_cnt_q;
  logic fifo_full, fifo_empty, pend_any, pend_onehot;
  logic accept, extract, pop, start_scan;

  // One comparator per page lane of the incoming block.
  for (genvar g = 0; g < PPB; g++) begin : g_lane
    page_multi_match #(.P_SIZE(P_SIZE), .NPAT(NPAT)) u_match (
      .page     (blk_data[g*P_SIZE +: P_SIZE]),
      .patterns (pat_q),
      .en       (en_q),
      .match    (match_vec[g])
    );
  end

  // Enables: pattern j is live when j < count; counts above NPAT clamp naturally.
  always_comb begin
    en_d = '0;
    for (int j = 0; j < NPAT; j++) en_d[j] = (int'(num_real_patterns) > j);
  end

  // Lowest set bit of the pending mask (ascending page order).
  always_comb begin
    low_idx = '0;
    for (int i = PPB - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = BIT_W'(i);
    end
  end

  assign pend_any    = |pending_q;
  assign pend_clr    = pending_q & (pending_q - PPB'(1));
  assign pend_onehot = pend_any && (pend_clr == '0);
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign fifo_full   = (fifo_cnt_q == (PTR_W+1)'(OUT_DEPTH));
  assign push_data   = NOP_WIDTH'(blk_idx_q) * NOP_WIDTH'(PPB) + NOP_WIDTH'(low_idx);

  // A new block may enter only if the current one empties this cycle.
  assign blk_ready  = (state_q == SCAN) && (blk_cnt_q < CNT_W'(NOB)) &&
                      (!pend_any || (pend_onehot && !fifo_full));
  assign accept     = blk_valid && blk_ready;
  assign extract    = pend_any && !fifo_full;
  assign pop        = !fifo_empty && tpn_ready;
  assign start_scan = (state_q == IDLE) && start;

  assign tpn_valid = !fifo_empty;
  assign tpn_data  = fifo_mem[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SCAN;
      SCAN:  if ((blk_cnt_q == CNT_W'(NOB)) && !pend_any) state_d = DRAIN;
      DRAIN: if (fifo_empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state elements use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Scan configuration, block counters, pending mask and match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= '0;
      en_q        <= '0;
      blk_cnt_q   <= '0;
      blk_idx_q   <= '0;
      pending_q   <= '0;
      match_count <= '0;
    end else begin
      if (start_scan) begin
        pat_q       <= patterns;
        en_q        <= en_d;
        blk_cnt_q   <= '0;
        match_count <= '0;
      end else begin
        if (accept) begin
          blk_idx_q <= blk_cnt_q[IDX_W-1:0];
          blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        end
        if (extract) match_count <= match_count + (NOP_WIDTH+1)'(1);
      end
      if (accept)       pending_q <= match_vec;
      else if (extract) pending_q <= pend_clr;
    end
  end

  // Output FIFO: push from the extractor, pop by the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is cleared on reset so the show-ahead head reads zero after reset.
      for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (extract) begin
        fifo_mem[wr_ptr_q] <= push_data;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({extract, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
